// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller:
// instruction-type codes, forward-select codes and the stall FSM states.
package hazard_pkg;

  localparam logic [3:0] ALU_REG = 4'd0;
  localparam logic [3:0] ALU_IMM = 4'd1;
  localparam logic [3:0] LOAD    = 4'd2;
  localparam logic [3:0] STORE   = 4'd3;
  localparam logic [3:0] HMOVE   = 4'd10;
  localparam logic [3:0] VMOVE   = 4'd11;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_FLUSH     = 2'd2
  } state_e;

  // Types whose Rt feeds the ALU B input as a register operand.
  function automatic logic rt_is_alu_src(input logic [3:0] ty);
    return (ty == ALU_REG) || (ty == HMOVE) || (ty == VMOVE);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: register indices and write
// enables from ID/EX/MEM/WB in, forward selects and pipeline enables out.
interface hazard_ctrl_if #(
  parameter int REG_W = 4
);
  logic [REG_W-1:0] idRs;
  logic [REG_W-1:0] idRt;
  logic             idUsesRs;
  logic             idUsesRt;
  logic [3:0]       exInstrType;
  logic [REG_W-1:0] exRs;
  logic [REG_W-1:0] exRt;
  logic [REG_W-1:0] exRd;
  logic             exRegWrite;
  logic             exBranchTaken;
  logic [REG_W-1:0] memRd;
  logic             memRegWrite;
  logic [REG_W-1:0] wbRd;
  logic             wbRegWrite;
  logic [1:0]       fwdA;
  logic [1:0]       fwdB;
  logic [1:0]       fwdStore;
  logic             pcWrite;
  logic             ifidWrite;
  logic             idexBubble;
  logic             ifidFlush;
  logic             stallBusy;

  // No valid/ready handshake here: every input is a level sampled each cycle,
  // and every output is a level the pipeline obeys in the same cycle.
  modport master (
    output idRs, idRt, idUsesRs, idUsesRt, exInstrType, exRs, exRt, exRd,
           exRegWrite, exBranchTaken, memRd, memRegWrite, wbRd, wbRegWrite,
    input  fwdA, fwdB, fwdStore, pcWrite, ifidWrite, idexBubble, ifidFlush,
           stallBusy
  );

  modport slave (
    input  idRs, idRt, idUsesRs, idUsesRt, exInstrType, exRs, exRt, exRd,
           exRegWrite, exBranchTaken, memRd, memRegWrite, wbRd, wbRegWrite,
    output fwdA, fwdB, fwdStore, pcWrite, ifidWrite, idexBubble, ifidFlush,
           stallBusy
  );

endinterface

// File: rtl/fwd_sel.sv
// Forward-source priority for one EX operand: the EX/MEM result beats the
// MEM/WB result, and register 0 is never forwarded.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic             i_en,
  input  logic [REG_W-1:0] i_src,
  input  logic [REG_W-1:0] i_mem_rd,
  input  logic             i_mem_we,
  input  logic [REG_W-1:0] i_wb_rd,
  input  logic             i_wb_we,
  output logic [1:0]       o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = i_mem_we && (i_mem_rd != '0) && (i_mem_rd == i_src);
  assign w_wb_hit  = i_wb_we  && (i_wb_rd  != '0) && (i_wb_rd  == i_src);

  always_comb begin
    o_sel = FWD_NONE;
    if (i_en) begin
      if (w_mem_hit)     o_sel = FWD_MEM;
      else if (w_wb_hit) o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: EX operand forwarding, load-use
// stall sequencing and taken-branch flushes.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W   = 4,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 2
) (
  input  logic           clk,
  input  logic           rst,
  hazard_ctrl_if.slave   bus,
  output state_e         o_dbg_state
);

  localparam logic [CNT_W-1:0] LW_CNT = CNT_W'(MEM_LAT - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic w_en_a;
  logic w_en_b;
  logic w_en_s;
  logic w_load_use;

  // Forwarding is forced to the plain ID/EX operands while in reset.
  assign w_en_a = !rst;
  assign w_en_b = !rst && rt_is_alu_src(bus.exInstrType);
  assign w_en_s = !rst && (bus.exInstrType == STORE);

  fwd_sel #(.REG_W(REG_W)) u_fwd_a (
    .i_en(w_en_a), .i_src(bus.exRs),
    .i_mem_rd(bus.memRd), .i_mem_we(bus.memRegWrite),
    .i_wb_rd(bus.wbRd), .i_wb_we(bus.wbRegWrite), .o_sel(bus.fwdA)
  );

  fwd_sel #(.REG_W(REG_W)) u_fwd_b (
    .i_en(w_en_b), .i_src(bus.exRt),
    .i_mem_rd(bus.memRd), .i_mem_we(bus.memRegWrite),
    .i_wb_rd(bus.wbRd), .i_wb_we(bus.wbRegWrite), .o_sel(bus.fwdB)
  );

  fwd_sel #(.REG_W(REG_W)) u_fwd_s (
    .i_en(w_en_s), .i_src(bus.exRt),
    .i_mem_rd(bus.memRd), .i_mem_we(bus.memRegWrite),
    .i_wb_rd(bus.wbRd), .i_wb_we(bus.wbRegWrite), .o_sel(bus.fwdStore)
  );

  assign w_load_use = (bus.exInstrType == LOAD) && bus.exRegWrite &&
                      (bus.exRd != '0) &&
                      ((bus.idUsesRs && (bus.idRs == bus.exRd)) ||
                       (bus.idUsesRt && (bus.idRt == bus.exRd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The first stall/flush cycle is driven combinationally from RUN, so the
  // registered states only cover the cycles after the detecting one.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    bus.pcWrite    = 1'b1;
    bus.ifidWrite  = 1'b1;
    bus.idexBubble = 1'b0;
    bus.ifidFlush  = 1'b0;
    bus.stallBusy  = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_RUN: begin
          if (bus.exBranchTaken) begin
            bus.ifidFlush  = 1'b1;
            bus.idexBubble = 1'b1;
            w_state_nxt    = ST_FLUSH;
          end else if (w_load_use) begin
            bus.pcWrite    = 1'b0;
            bus.ifidWrite  = 1'b0;
            bus.idexBubble = 1'b1;
            if (MEM_LAT > 1) begin
              w_state_nxt = ST_LOAD_WAIT;
              w_cnt_nxt   = LW_CNT;
            end
          end
        end
        ST_LOAD_WAIT: begin
          bus.stallBusy  = 1'b1;
          bus.pcWrite    = 1'b0;
          bus.ifidWrite  = 1'b0;
          bus.idexBubble = 1'b1;
          // The count is left at zero on the way out; it never wraps.
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        ST_FLUSH: begin
          bus.stallBusy = 1'b1;
          w_state_nxt   = ST_RUN;
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core.
- Combinationally selects operand forwarding for the EX-stage ALU A input, B input and store-data path.
- Sequences load-use stalls through a small FSM with a latency counter.
- Issues IF/ID and ID/EX flushes on taken branches.
- Its fwdB output feeds the ALU source-B mux ahead of the non-forward source-B select.

Parameters:
- REG_W, 4, register index width
- MEM_LAT, 2, data-memory read latency in cycles (>=1); load-use stall length
- CNT_W, 2, counter width, must hold MEM_LAT

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- idRs  in  REG_W  ID-stage source A register
- idRt  in  REG_W  ID-stage source B register
- idUsesRs  in  1  ID instruction reads Rs
- idUsesRt  in  1  ID instruction reads Rt
- exInstrType  in  4  ID/EX instruction type (pkg codes)
- exRs  in  REG_W  ID/EX source A
- exRt  in  REG_W  ID/EX source B
- exRd  in  REG_W  ID/EX destination
- exRegWrite  in  1  ID/EX writes register file
- exBranchTaken  in  1  branch resolved taken in EX
- memRd  in  REG_W  EX/MEM destination
- memRegWrite  in  1  EX/MEM writes register file
- wbRd  in  REG_W  MEM/WB destination
- wbRegWrite  in  1  MEM/WB writes register file
- fwdA  out  2  ALU A select: 00 ID/EX A, 01 EX/MEM result, 10 MEM/WB result
- fwdB  out  2  ALU B forward select, same encoding
- fwdStore  out  2  store-data select, same encoding
- pcWrite  out  1  PC enable
- ifidWrite  out  1  IF/ID enable
- idexBubble  out  1  load NOP into ID/EX
- ifidFlush  out  1  clear IF/ID
- stallBusy  out  1  FSM not in RUN

Behaviour:
- Forwarding (combinational, EX stage):
  - Priority: EX/MEM over MEM/WB.
  - Match requires RegWrite=1 and Rd != 0. Register 0 is never forwarded.
  - fwdA matches on exRs.
  - fwdB matches on exRt only for types ALU-reg (0) and vmove/hmove (10, 11). Otherwise fwdB=00, and the immediate/constant select downstream applies.
  - fwdStore matches on exRt for type Store (3). Otherwise 00.
- Load-use detect:
  - Condition: exInstrType=Load (2), exRegWrite=1, exRd!=0, and ((idUsesRs & idRs==exRd) | (idUsesRt & idRt==exRd)).
- FSM, states RUN, LOAD_WAIT, FLUSH; state and counter are registered:
  - RUN: all enables =1, bubble/flush =0.
    - exBranchTaken -> FLUSH.
    - Else load-use -> LOAD_WAIT with cnt=MEM_LAT-1.
  - LOAD_WAIT: pcWrite=0, ifidWrite=0, idexBubble=1.
    - Stall is asserted in the detect cycle itself (combinational from RUN), total MEM_LAT stall cycles.
    - Decrement cnt; at cnt==0 -> RUN.
    - If MEM_LAT=1, no LOAD_WAIT entry: single combinational stall cycle, state stays RUN.
  - FLUSH: the taken-branch cycle asserts ifidFlush=1 and idexBubble=1 combinationally from RUN. FLUSH lasts one cycle with pcWrite=1 and no further flush, then -> RUN. Its purpose is to block a re-detected stale hazard.
- Simultaneous events:
  - exBranchTaken and load-use in the same cycle: branch wins, no stall.
  - Branch is never resolved while in LOAD_WAIT, because EX holds a bubble.
- Reset:
  - rst is synchronous; state=RUN, cnt=0.
  - Output values during and after reset: fwd*=00, pcWrite=1, ifidWrite=1, idexBubble=0, ifidFlush=0, stallBusy=0.
  - rst mid-LOAD_WAIT aborts the stall on the next edge.
- Wrap-around: cnt never underflows; the transition occurs at 0.

Decomposition:
- Package hazard_pkg holds:
  - Instruction-type constants: ALU_REG=0, ALU_IMM=1, LOAD=2, STORE=3, HMOVE=10, VMOVE=11.
  - Forward-select constants: FWD_NONE=00, FWD_MEM=01, FWD_WB=10.
  - FSM state enum.
- One sub-module, fwd_sel: pure-combinational forward priority logic, instantiated three times (A, B, store) with per-instance enable.

Test Plan:
- ALU-reg r3 in MEM (memRegWrite=1, memRd=3) and r3 in WB; EX exRs=3 -> fwdA=01. Then clear memRegWrite -> fwdA=10.
- exRd match with memRd=0, memRegWrite=1 -> fwdA=fwdB=00.
- Load r5 in EX, ID reads idRt=5, MEM_LAT=2 -> pcWrite=0, ifidWrite=0, idexBubble=1 for exactly 2 cycles. stallBusy=1 in the second cycle only. Then RUN.
- exBranchTaken=1 with simultaneous load-use -> ifidFlush=1, idexBubble=1 for one cycle, pcWrite=1, no LOAD_WAIT entry.
- Store in EX with exRt=7, memRd=7, memRegWrite=1 -> fwdStore=01, fwdB=00. ALU-imm with same match -> fwdB=00.
- rst asserted in first LOAD_WAIT cycle -> next cycle state RUN, pcWrite=1, idexBubble=0.
